alu_serial_seq: RTL
===================

Name: alu_serial_seq

Overview:
- Bit-serial ALU sequencer: performs a full WIDTH-bit MIPS-style ALU operation by driving a single 1-bit ALU slice over WIDTH cycles, LSB first.
- Carry is held in a flop between cycles.
- Sits between a requester (lab CPU / testbench) and the 1-bit slice. Trades latency for area.
- Uses valid/ready handshakes on both the operand and the result sides.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of the bit-index counter (derived; not overridden).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset, active low, sampled on rising clk.
- in_valid  in  1  operand request valid.
- in_ready  out  1  sequencer can accept a request; high only in IDLE.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- alu_ctrl  in  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow; ADD/SUB only, else 0.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low.
- Reset values while rst_n=0 at a clk edge:
  - state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0.
  - Counter, carry and latched operands/op all cleared.
  - Reset mid-operation aborts it; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch src_a, src_b and alu_ctrl, clear the bit counter, go to RUN.
  - The carry flop is preloaded to 1 for SUB/SLT and 0 otherwise.
  - Inputs are ignored outside the accepting edge.
- RUN, one bit per cycle (bit i = counter):
  - Slice decode: a_invert=1 for NOR; b_invert=1 for SUB, SLT and NOR; operation=AND for AND/NOR, OR for OR, ADD for ADD/SUB/SLT.
  - The slice "less" input is tied to 0.
  - The slice result is written into result_shadow[i]; the carry flop takes the slice carry_out.
  - At i=WIDTH-1, capture ovf = carry_into_msb ^ carry_out_msb and sign = sum_msb.
  - Then go to SLT_FIX if op=SLT, else DONE.
- SLT_FIX (one cycle): result_shadow = {WIDTH-1 zeros, sign ^ ovf}; go to DONE.
- DONE:
  - out_valid=1; result, zero and overflow are driven from registers.
  - These outputs hold stable while out_ready=0 (unbounded backpressure).
  - On out_valid&&out_ready, go to IDLE. One idle cycle is always inserted between back-to-back operations.
- Latency: request accepted at edge E.
  - out_valid rises after edge E+WIDTH+1 for AND/OR/ADD/SUB/NOR.
  - out_valid rises after edge E+WIDTH+2 for SLT.
- Flags:
  - overflow = ovf for ADD/SUB, 0 for AND/OR/NOR/SLT.
  - zero is computed from the final result, including SLT.
- Arithmetic is modulo 2^WIDTH; there is no carry_out port.
- Illegal alu_ctrl: runs WIDTH cycles, returns result=0, zero=1, overflow=0. Never hangs.
- Simultaneous in_valid while busy: not accepted (in_ready=0); the requester must hold its request.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- When defined:
  - Extra output perf_ops (16 bits): counts completed result handshakes.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_CTRL opcode constants (AND/OR/ADD/SUB/SLT/NOR).
  - Slice operation encodings (2'b00 AND, 2'b01 OR, 2'b10 ADD, 2'b11 LESS).
  - Sequencer state enum (IDLE, RUN, SLT_FIX, DONE).
- One sub-module: alu_bit_slice, the combinational 1-bit ALU (a, b, less, a_invert, b_invert, carry_in, operation -> result, carry_out).
- alu_bit_slice is instantiated once; the decode and FSM stay in alu_serial_seq.

Test Plan:
- ADD 5 + 3, out_ready=1 -> result=8, zero=0, overflow=0; out_valid first high 33 cycles after accept (WIDTH=32).
- SUB 3 - 5 -> result=32'hFFFFFFFE, overflow=0; ADD 32'h7FFFFFFF + 1 -> result=32'h80000000, overflow=1.
- SLT -5 vs 3 -> result=1 after 34 cycles; SLT 32'h80000000 vs 1 -> 1; SLT 7 vs 7 -> 0, zero=1.
- NOR 0,0 -> 32'hFFFFFFFF; AND 32'hF0F0F0F0, 32'h0F0F0F0F -> 0, zero=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> result and flags stable, in_ready=0.
  - A new in_valid during that window is not accepted; it is accepted one cycle after the result handshake.
- rst_n low for one edge at bit 16 of an ADD -> next cycle: IDLE, in_ready=1, out_valid=0, result=0. A following ADD 1+1 -> 2.
- With ALU_SEQ_PERF_EN: three completed ops -> perf_ops=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: MIPS-style ALU
// control opcodes, 1-bit slice operation encodings and the sequencer states.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    SL_AND  = 2'b00,
    SL_OR   = 2'b01,
    SL_ADD  = 2'b10,
    SL_LESS = 2'b11
  } slice_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SLT_FIX,
    ST_DONE
  } seq_state_e;

  // True for the six opcodes the sequencer implements.
  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    return (ctrl == CTRL_AND) || (ctrl == CTRL_OR)  || (ctrl == CTRL_ADD) ||
           (ctrl == CTRL_SUB) || (ctrl == CTRL_SLT) || (ctrl == CTRL_NOR);
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Operand/result handshake bundle of the bit-serial ALU sequencer.
// master = requester side, slave = sequencer side.
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, src_a, src_b, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, src_a, src_b, alu_ctrl, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit MIPS-style ALU slice with operand inversion,
// full-adder carry chain and a pass-through "less" input.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic      less,
  input  logic      a_invert,
  input  logic      b_invert,
  input  logic      carry_in,
  input  slice_op_e operation,
  output logic      result,
  output logic      carry_out
);

  logic a_eff;
  logic b_eff;
  logic sum;

  assign a_eff     = a ^ a_invert;
  assign b_eff     = b ^ b_invert;
  assign sum       = a_eff ^ b_eff ^ carry_in;
  assign carry_out = (a_eff & b_eff) | (a_eff & carry_in) | (b_eff & carry_in);

  // Select the slice output for the requested operation.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    result = 1'b0;
    case (operation)
      SL_AND:  result = a_eff & b_eff;
      SL_OR:   result = a_eff | b_eff;
      SL_ADD:  result = sum;
      SL_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: runs one WIDTH-bit ALU operation through a single
// 1-bit slice, LSB first, one bit per clock, with the carry held in a flop.
// Optional macro ALU_SEQ_PERF_EN adds a saturating 16-bit count (perf_ops)
// of completed result handshakes.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_serial_seq_if.slave   bus
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_ops
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  seq_state_e       state;
  seq_state_e       next_state;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_ctrl;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic             ovf;
  logic             sign;
  logic [WIDTH-1:0] result_shadow;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             out_valid_q;

  logic             accept;
  logic             last_bit;
  logic             handshake;

  logic             a_invert;
  logic             b_invert;
  slice_op_e        slice_op;
  logic             op_legal;
  logic             slice_result;
  logic             slice_carry_out;

  assign accept    = (state == ST_IDLE) && bus.in_valid;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign handshake = (state == ST_DONE) && out_valid_q && bus.out_ready;

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;

  // Decode the latched opcode into slice controls.
  always_comb begin
    a_invert = 1'b0;
    b_invert = 1'b0;
    slice_op = SL_AND;
    op_legal = is_legal_ctrl(op_ctrl);
    case (op_ctrl)
      CTRL_AND: slice_op = SL_AND;
      CTRL_OR:  slice_op = SL_OR;
      CTRL_ADD: slice_op = SL_ADD;
      CTRL_SUB: begin slice_op = SL_ADD; b_invert = 1'b1; end
      CTRL_SLT: begin slice_op = SL_ADD; b_invert = 1'b1; end
      CTRL_NOR: begin slice_op = SL_AND; a_invert = 1'b1; b_invert = 1'b1; end
      default:  slice_op = SL_AND;
    endcase
  end

  alu_bit_slice u_slice (
    .a         (op_a[bit_cnt]),
    .b         (op_b[bit_cnt]),
    .less      (1'b0),
    .a_invert  (a_invert),
    .b_invert  (b_invert),
    .carry_in  (carry),
    .operation (slice_op),
    .result    (slice_result),
    .carry_out (slice_carry_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (accept) next_state = ST_RUN;
      ST_RUN:     if (last_bit) next_state = (op_ctrl == CTRL_SLT) ? ST_SLT_FIX : ST_DONE;
      ST_SLT_FIX: next_state = ST_DONE;
      ST_DONE:    if (handshake) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Operand latch, serial datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the result shadow is a plain register, not a RAM, so it is cleared with the rest of the state.
      op_a          <= '0;
      op_b          <= '0;
      op_ctrl       <= '0;
      bit_cnt       <= '0;
      carry         <= 1'b0;
      ovf           <= 1'b0;
      sign          <= 1'b0;
      result_shadow <= '0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      overflow_q    <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a    <= bus.src_a;
            op_b    <= bus.src_b;
            op_ctrl <= bus.alu_ctrl;
            bit_cnt <= '0;
            carry   <= (bus.alu_ctrl == CTRL_SUB) || (bus.alu_ctrl == CTRL_SLT);
            ovf     <= 1'b0;
            sign    <= 1'b0;
          end
        end
        ST_RUN: begin
          result_shadow[bit_cnt] <= op_legal & slice_result;
          carry                  <= slice_carry_out;
          if (last_bit) begin
            ovf  <= carry ^ slice_carry_out;
            sign <= slice_result;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_SLT_FIX: begin
          result_shadow <= {{(WIDTH-1){1'b0}}, sign ^ ovf};
        end
        ST_DONE: begin
          // First DONE cycle loads the output registers; they then hold until the handshake.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= result_shadow;
            zero_q      <= (result_shadow == '0);
            overflow_q  <= ((op_ctrl == CTRL_ADD) || (op_ctrl == CTRL_SUB)) & ovf;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Saturating count of completed result handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n)                              perf_ops <= '0;
    else if (handshake && perf_ops != 16'hFFFF) perf_ops <= perf_ops + 16'd1;
  end
`endif

endmodule
